// File: rtl/armleo_axi_pkg.sv
// Shared AXI definitions for the burst BRAM slave: response and burst codes,
// FSM state type, response ranking and next-beat address calculation.
package armleo_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} bram_state_t;

  // Rank responses DECERR > SLVERR > OKAY and return the worse one.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Address of the following beat; works on 64 bits so any narrower bus can
  // truncate the result, which gives the modulo-2^ADDR_WIDTH wrap for free.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr, input logic [1:0] burst,
                                                input logic [7:0] len, input logic [2:0] size_enum);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'd1 << size_enum;
    mask = ((64'(len) + 64'd1) << size_enum) - 64'd1;
    case (burst)
      BURST_INCR: return addr + step;
      BURST_WRAP: return (addr & ~mask) | ((addr + step) & mask);
      default:    return addr;
    endcase
  endfunction

endpackage

// File: rtl/armleo_axi_burst_addr_gen.sv
// Beat address generator shared by the read and write paths. Holds the
// address of the current beat and how many beats follow it.
module armleo_axi_burst_addr_gen
  import armleo_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_ENUM  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_len,
  input  logic [1:0]            load_burst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [7:0]            remaining,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SIZE_ENUM) - 1);

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            remaining_reg;
  logic [7:0]            len_reg;
  logic [1:0]            burst_reg;
  logic [63:0]           next_full;

  assign next_full = axi_next_addr(64'(addr_reg), burst_reg, len_reg, 3'(SIZE_ENUM));
  assign next_addr = next_full[ADDR_WIDTH-1:0];
  assign addr      = addr_reg;
  assign remaining = remaining_reg;
  assign last      = (remaining_reg == 8'd0);

  if (ADDR_WIDTH < 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^next_full[63:ADDR_WIDTH];
  end

  // Load a new burst (word-aligned start) or step to the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      remaining_reg <= 8'd0;
      len_reg       <= 8'd0;
      burst_reg     <= BURST_INCR;
    end else if (load) begin
      addr_reg      <= load_addr & ALIGN_MASK;
      remaining_reg <= load_len;
      len_reg       <= load_len;
      burst_reg     <= load_burst;
    end else if (advance) begin
      addr_reg <= next_addr;
      if (remaining_reg != 8'd0) remaining_reg <= remaining_reg - 8'd1;
    end
  end

endmodule

// File: rtl/armleo_mem_1rwm.sv
// Single-port block RAM with per-byte write mask and registered read data.
// Read data only changes on a read access, so it holds while the port is idle.
module armleo_mem_1rwm #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       wmask,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_array [DEPTH];

  // Byte-masked write or registered read, never both in one cycle.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (wmask[i]) mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end else if (en) begin
      rdata <= mem_array[addr];
    end
  end

endmodule

// File: rtl/armleo_axi_bram_burst.sv
// AXI4 burst slave in front of a single-port block RAM.
// Optional WRAP support: define ARMLEO_AXI_BRAM_BURST_WRAP_EN; without it
// WRAP requests are answered SLVERR on every beat but keep their length.
module armleo_axi_bram_burst
  import armleo_axi_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_WIDTH_ENUM = 5,
  localparam int DW             = 1 << DATA_WIDTH_ENUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [2:0]            axi_awsize,
  input  logic [1:0]            axi_awburst,
  input  logic [ID_WIDTH-1:0]   axi_awid,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DW-1:0]         axi_wdata,
  input  logic [DW/8-1:0]       axi_wstrb,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  output logic [ID_WIDTH-1:0]   axi_bid,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [2:0]            axi_arsize,
  input  logic [1:0]            axi_arburst,
  input  logic [ID_WIDTH-1:0]   axi_arid,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic [DW-1:0]         axi_rdata,
  output logic [ID_WIDTH-1:0]   axi_rid
);

  localparam int SZ     = DATA_WIDTH_ENUM - 3;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [2:0] SIZE_OK = 3'(SZ);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SZ) - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(DEPTH << SZ);
`ifdef ARMLEO_AXI_BRAM_BURST_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // A request that is malformed fails every one of its beats.
  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != SIZE_OK) || (burst == 2'b11) || ((burst == BURST_WRAP) && !(WRAP_EN && wrap_len_ok));
  endfunction

  function automatic logic [1:0] beat_resp(input logic bad, input logic [ADDR_WIDTH-1:0] addr);
    if (bad) return RESP_SLVERR;
    if (addr >= MEM_BYTES) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  bram_state_t           state_reg;
  logic                  prio_write_reg;
  logic                  bad_reg;
  logic                  overflow_reg;
  logic [1:0]            acc_resp_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic                  rvalid_reg;
  logic [1:0]            rresp_reg;
  logic [ID_WIDTH-1:0]   id_reg;

  logic                  aw_grant, ar_grant, aw_bad, ar_bad;
  logic                  w_hs, r_hs;
  logic [ADDR_WIDTH-1:0] ar_aligned;
  logic [1:0]            ar_resp, w_resp, rn_resp, w_beat, w_fold;
  logic [ADDR_WIDTH-1:0] gen_addr, gen_next_addr;
  logic [7:0]            gen_remaining;
  logic                  gen_last, gen_load, gen_advance;
  logic                  mem_en, mem_we;
  logic [MEM_AW-1:0]     mem_idx;
  logic [DW-1:0]         mem_rdata;
  logic                  unused_remaining;

  assign aw_grant    = axi_awvalid && (!axi_arvalid || prio_write_reg);
  assign ar_grant    = axi_arvalid && !aw_grant;
  assign axi_awready = (state_reg == IDLE) && !rst && aw_grant;
  assign axi_arready = (state_reg == IDLE) && !rst && ar_grant;
  assign axi_wready  = (state_reg == WRITE) && !rst;
  assign w_hs        = axi_wvalid && axi_wready;
  assign r_hs        = rvalid_reg && axi_rready;

  assign aw_bad     = req_bad(axi_awsize, axi_awburst, axi_awlen);
  assign ar_bad     = req_bad(axi_arsize, axi_arburst, axi_arlen);
  assign ar_aligned = axi_araddr & ALIGN_MASK;
  assign ar_resp    = beat_resp(ar_bad, ar_aligned);
  assign w_resp     = beat_resp(bad_reg, gen_addr);
  assign rn_resp    = beat_resp(bad_reg, gen_next_addr);

  assign axi_bvalid = bvalid_reg;
  assign axi_bresp  = bresp_reg;
  assign axi_bid    = id_reg;
  assign axi_rvalid = rvalid_reg;
  assign axi_rresp  = rresp_reg;
  assign axi_rid    = id_reg;
  assign axi_rlast  = rvalid_reg && gen_last;
  assign axi_rdata  = (rvalid_reg && rresp_reg == RESP_OKAY) ? mem_rdata : '0;
  assign unused_remaining = ^gen_remaining;

  assign gen_load    = axi_awready || axi_arready;
  assign gen_advance = (w_hs && !axi_wlast && !gen_last && !overflow_reg)
                    || ((state_reg == READ) && r_hs && !gen_last);

  armleo_axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE_ENUM  (SZ)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (gen_load),
    .advance    (gen_advance),
    .load_addr  (axi_awready ? axi_awaddr : axi_araddr),
    .load_len   (axi_awready ? axi_awlen : axi_arlen),
    .load_burst (axi_awready ? axi_awburst : axi_arburst),
    .addr       (gen_addr),
    .next_addr  (gen_next_addr),
    .remaining  (gen_remaining),
    .last       (gen_last)
  );

  armleo_mem_1rwm #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (axi_wdata),
    .wmask (axi_wstrb),
    .rdata (mem_rdata)
  );

  // Fold this write beat into the burst response; a missing or early wlast adds SLVERR.
  always_comb begin
    w_beat = overflow_reg ? RESP_SLVERR : w_resp;
    if (axi_wlast ? (!gen_last && !overflow_reg) : gen_last) w_beat = resp_worst(w_beat, RESP_SLVERR);
    w_fold = resp_worst(acc_resp_reg, w_beat);
  end

  // Memory port: AR accept, write beat or next read beat, mutually exclusive by state.
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    mem_idx = gen_addr[MEM_AW+SZ-1:SZ];
    if (axi_arready) begin
      mem_en  = (ar_resp == RESP_OKAY);
      mem_idx = ar_aligned[MEM_AW+SZ-1:SZ];
    end else if (w_hs && !overflow_reg) begin
      mem_en = (w_resp == RESP_OKAY);
      mem_we = 1'b1;
    end else if ((state_reg == READ) && r_hs && !gen_last) begin
      mem_en  = (rn_resp == RESP_OKAY);
      mem_idx = gen_next_addr[MEM_AW+SZ-1:SZ];
    end
  end

  // Main FSM: arbitration, write burst tracking, B response and read beat sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prio_write_reg <= 1'b1;
      bad_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      acc_resp_reg   <= RESP_OKAY;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      rvalid_reg     <= 1'b0;
      rresp_reg      <= RESP_OKAY;
      id_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (axi_awvalid && axi_arvalid) prio_write_reg <= !prio_write_reg;
          if (aw_grant) begin
            state_reg    <= WRITE;
            bad_reg      <= aw_bad;
            overflow_reg <= 1'b0;
            acc_resp_reg <= RESP_OKAY;
            id_reg       <= axi_awid;
          end else if (ar_grant) begin
            state_reg  <= READ;
            bad_reg    <= ar_bad;
            id_reg     <= axi_arid;
            rvalid_reg <= 1'b1;
            rresp_reg  <= ar_resp;
          end
        end
        WRITE: begin
          if (w_hs) begin
            acc_resp_reg <= w_fold;
            if (axi_wlast) begin
              state_reg  <= WRITE_RESP;
              bvalid_reg <= 1'b1;
              bresp_reg  <= w_fold;
            end else if (gen_last) begin
              overflow_reg <= 1'b1;
            end
          end
        end
        WRITE_RESP: begin
          if (axi_bready) begin
            bvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        READ: begin
          if (r_hs) begin
            if (gen_last) begin
              rvalid_reg <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              rresp_reg <= rn_resp;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleo_axi_bram_burst.sv
// Directed self-checking bench for armleo_axi_bram_burst (32-bit, DEPTH 1024).
// Expectations for the WRAP case follow ARMLEO_AXI_BRAM_BURST_WRAP_EN.
module tb_armleo_axi_bram_burst;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awid;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arid;
  logic        axi_rvalid, axi_rready, axi_rlast;
  logic [1:0]  axi_rresp;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  armleo_axi_bram_burst dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awid(axi_awid),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arid(axi_arid),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata), .axi_rid(axi_rid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    axi_awaddr = a; axi_awlen = l; axi_awburst = b; axi_awsize = s; axi_awid = id; axi_awvalid = 1'b1;
    #1;
    while (!axi_awready && n < 20) begin @(negedge clk); #1; n++; end
    check("aw_accept", 64'(axi_awready), 64'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    axi_araddr = a; axi_arlen = l; axi_arburst = b; axi_arsize = s; axi_arid = id; axi_arvalid = 1'b1;
    #1;
    while (!axi_arready && n < 20) begin @(negedge clk); #1; n++; end
    check("ar_accept", 64'(axi_arready), 64'd1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    axi_wdata = d; axi_wstrb = 4'hF; axi_wlast = last; axi_wvalid = 1'b1;
    #1;
    while (!axi_wready && n < 20) begin @(negedge clk); #1; n++; end
    check("w_accept", 64'(axi_wready), 64'd1);
    @(posedge clk); #1;
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
  endtask

  task automatic recv_b(input logic [1:0] exp_resp, input logic [3:0] exp_id, input string tag);
    int n = 0;
    @(negedge clk);
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 20) begin @(negedge clk); n++; end
    $display("[TB] B %s resp=%0d id=%0h", tag, axi_bresp, axi_bid);
    check({tag, "_bvalid"}, 64'(axi_bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(axi_bresp), 64'(exp_resp));
    check({tag, "_bid"}, 64'(axi_bid), 64'(exp_id));
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic recv_r(input logic [31:0] exp_data, input logic [1:0] exp_resp, input logic exp_last,
                        input logic [3:0] exp_id, input string tag);
    int n = 0;
    @(negedge clk);
    axi_rready = 1'b1;
    while (!axi_rvalid && n < 20) begin @(negedge clk); n++; end
    $display("[TB] R %s data=%h resp=%0d last=%0d id=%0h", tag, axi_rdata, axi_rresp, axi_rlast, axi_rid);
    check({tag, "_rvalid"}, 64'(axi_rvalid), 64'd1);
    check({tag, "_rdata"}, 64'(axi_rdata), 64'(exp_data));
    check({tag, "_rresp"}, 64'(axi_rresp), 64'(exp_resp));
    check({tag, "_rlast"}, 64'(axi_rlast), 64'(exp_last));
    check({tag, "_rid"}, 64'(axi_rid), 64'(exp_id));
    @(posedge clk); #1;
    axi_rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    axi_awvalid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 3'd2; axi_awburst = INCR; axi_awid = 0;
    axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
    axi_arvalid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 3'd2; axi_arburst = INCR; axi_arid = 0;
    axi_rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(axi_awready), 64'd0);
    check("rst_arready", 64'(axi_arready), 64'd0);
    check("rst_wready", 64'(axi_wready), 64'd0);
    check("rst_bvalid", 64'(axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("rst_rlast", 64'(axi_rlast), 64'd0);
    check("rst_bresp", 64'(axi_bresp), 64'(OKAY));
    check("rst_rresp", 64'(axi_rresp), 64'(OKAY));
    check("rst_rdata", 64'(axi_rdata), 64'd0);
    rst = 1'b0;

    // Simultaneous AW/AR out of reset: write wins, then read wins.
    @(negedge clk);
    axi_awaddr = 32'h100; axi_awlen = 0; axi_awburst = INCR; axi_awsize = 3'd2; axi_awid = 4'h1;
    axi_araddr = 32'h100; axi_arlen = 0; axi_arburst = INCR; axi_arsize = 3'd2; axi_arid = 4'h2;
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    #1;
    check("arb1_awready", 64'(axi_awready), 64'd1);
    check("arb1_arready", 64'(axi_arready), 64'd0);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    send_w(32'h55, 1'b1);
    recv_b(OKAY, 4'h1, "arb_w");
    @(negedge clk);
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    #1;
    check("arb2_awready", 64'(axi_awready), 64'd0);
    check("arb2_arready", 64'(axi_arready), 64'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    recv_r(32'h55, OKAY, 1'b1, 4'h2, "arb_r");

    // INCR write then read back of four beats at 0x10.
    send_aw(32'h10, 8'd3, INCR, 3'd2, 4'h3);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), i == 3);
    recv_b(OKAY, 4'h3, "incr_w");
    send_ar(32'h10, 8'd3, INCR, 3'd2, 4'h4);
    for (int i = 0; i < 4; i++) recv_r(32'hA0 + 32'(i), OKAY, i == 3, 4'h4, "incr_r");

    // Preload word[i]=i, then WRAP read from 0x0C.
    send_aw(32'h0, 8'd3, INCR, 3'd2, 4'h5);
    for (int i = 0; i < 4; i++) send_w(32'(i), i == 3);
    recv_b(OKAY, 4'h5, "preload_w");
    send_ar(32'h0C, 8'd3, WRAP, 3'd2, 4'h6);
`ifdef ARMLEO_AXI_BRAM_BURST_WRAP_EN
    recv_r(32'd3, OKAY, 1'b0, 4'h6, "wrap_r0");
    recv_r(32'd0, OKAY, 1'b0, 4'h6, "wrap_r1");
    recv_r(32'd1, OKAY, 1'b0, 4'h6, "wrap_r2");
    recv_r(32'd2, OKAY, 1'b1, 4'h6, "wrap_r3");
`else
    for (int i = 0; i < 4; i++) recv_r(32'd0, SLVERR, i == 3, 4'h6, "wrap_off_r");
`endif

    // Burst crossing the end of memory: first beat written, second DECERR.
    send_aw(32'hFFC, 8'd1, INCR, 3'd2, 4'h7);
    send_w(32'h11, 1'b0);
    send_w(32'h22, 1'b1);
    recv_b(DECERR, 4'h7, "edge_w");
    send_ar(32'hFFC, 8'd0, INCR, 3'd2, 4'h7);
    recv_r(32'h11, OKAY, 1'b1, 4'h7, "edge_r_in");
    send_ar(32'h1000, 8'd0, INCR, 3'd2, 4'h7);
    recv_r(32'h0, DECERR, 1'b1, 4'h7, "edge_r_out");

    // Read of three beats with rready low for three cycles mid-burst.
    send_ar(32'h10, 8'd2, INCR, 3'd2, 4'h8);
    recv_r(32'hA0, OKAY, 1'b0, 4'h8, "stall_b0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rvalid", 64'(axi_rvalid), 64'd1);
      check("stall_rdata", 64'(axi_rdata), 64'hA1);
      check("stall_rlast", 64'(axi_rlast), 64'd0);
    end
    recv_r(32'hA1, OKAY, 1'b0, 4'h8, "stall_b1");
    recv_r(32'hA2, OKAY, 1'b1, 4'h8, "stall_b2");

    // Early wlast on a len-3 write; bvalid must wait for bready.
    send_aw(32'h200, 8'd3, INCR, 3'd2, 4'h9);
    for (int i = 0; i < 3; i++) send_w(32'hB0 + 32'(i), i == 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bhold_bvalid", 64'(axi_bvalid), 64'd1);
    end
    recv_b(SLVERR, 4'h9, "early_wlast");

    // Missing wlast on the final beat: extra beat drained, SLVERR.
    send_aw(32'h300, 8'd1, INCR, 3'd2, 4'hA);
    for (int i = 0; i < 3; i++) send_w(32'hC0 + 32'(i), i == 2);
    recv_b(SLVERR, 4'hA, "late_wlast");

    // Wrong size is SLVERR and leaves memory untouched.
    send_aw(32'h400, 8'd0, INCR, 3'd2, 4'hB);
    send_w(32'h77, 1'b1);
    recv_b(OKAY, 4'hB, "size_pre");
    send_aw(32'h400, 8'd0, INCR, 3'd3, 4'hB);
    send_w(32'h88, 1'b1);
    recv_b(SLVERR, 4'hB, "size_bad");
    send_ar(32'h400, 8'd0, INCR, 3'd2, 4'hB);
    recv_r(32'h77, OKAY, 1'b1, 4'hB, "size_keep");

    // Reserved burst type on read: every beat SLVERR with zero data.
    send_ar(32'h10, 8'd1, 2'b11, 3'd2, 4'hC);
    recv_r(32'h0, SLVERR, 1'b0, 4'hC, "rsvd_b0");
    recv_r(32'h0, SLVERR, 1'b1, 4'hC, "rsvd_b1");

    // Reset pulsed during a read burst aborts it; a new AR works afterwards.
    send_ar(32'h10, 8'd3, INCR, 3'd2, 4'hD);
    recv_r(32'hA0, OKAY, 1'b0, 4'hD, "rstmid_b0");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_rvalid", 64'(axi_rvalid), 64'd0);
    check("rstmid_rlast", 64'(axi_rlast), 64'd0);
    rst = 1'b0;
    send_ar(32'h14, 8'd0, INCR, 3'd2, 4'hE);
    recv_r(32'hA1, OKAY, 1'b1, 4'hE, "rstmid_new");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
